// File: rtl/ravan_pkg.sv
// Shared RAVAN definitions: FSM state encoding, default parameters and the
// rotate / round-key helpers used by the iterative cipher.
package ravan_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int KEY_W_DEF  = 512;
  localparam int ROUNDS_DEF = 8;
  localparam int ROT_DEF    = 1;
  localparam int ID_W_DEF   = 4;
  localparam int ADDR_W_DEF = 16;

  // Helpers work on fixed-size containers; callers zero-extend in and truncate out.
  localparam int MAX_DW = 256;
  localparam int MAX_KW = 4096;

  typedef logic [MAX_DW-1:0] word_t;
  typedef logic [MAX_KW-1:0] kbus_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Rotate the low w bits of x left by r (upper bits of x must be zero).
  function automatic word_t rotl(input word_t x, input int w, input int r);
    word_t m;
    m = (word_t'(1) << w) - word_t'(1);
    return ((x << r) | (x >> (w - r))) & m;
  endfunction

  // Rotate the low w bits of x right by r (upper bits of x must be zero).
  function automatic word_t rotr(input word_t x, input int w, input int r);
    word_t m;
    m = (word_t'(1) << w) - word_t'(1);
    return ((x >> r) | (x << (w - r))) & m;
  endfunction

  // k[i] = w[i mod nw] XOR i, with i zero-extended to the block width dw.
  function automatic word_t round_key(input kbus_t key, input int i, input int dw, input int nw);
    word_t m;
    int    j;
    m = (word_t'(1) << dw) - word_t'(1);
    j = i % nw;
    return (word_t'(key >> (j * dw)) ^ word_t'(i)) & m;
  endfunction

endpackage

// File: rtl/ravan_round.sv
// One combinational RAVAN round. Encrypt: rotl(x ^ k). Decrypt: rotr(x) ^ k.
module ravan_round
  import ravan_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ROT    = ROT_DEF
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] k,
  input  logic              dec,
  output logic [DATA_W-1:0] x_next
);

  word_t w_x;
  word_t w_k;

  assign w_x = word_t'(x);
  assign w_k = word_t'(k);

  // Decrypt undoes the encrypt step in reverse order: rotate back, then strip the key.
  always_comb begin
    if (dec) x_next = DATA_W'(rotr(w_x, DATA_W, ROT) ^ w_k);
    else     x_next = DATA_W'(rotl(w_x ^ w_k, DATA_W, ROT));
  end

endmodule

// File: rtl/ravan_iter_cipher.sv
// Iterative RAVAN encrypt/decrypt core: one block per valid/ready transaction,
// one round per cycle, transaction ID carried to the result.
// Optional feature macro: RAVAN_ADDR_OUT_EN adds out_addr, the XOR-fold of the
// accepted key into ADDR_W-bit slices.
module ravan_iter_cipher
  import ravan_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int KEY_W  = KEY_W_DEF,
  parameter int ROUNDS = ROUNDS_DEF,
  parameter int ROT    = ROT_DEF,
  parameter int ID_W   = ID_W_DEF
`ifdef RAVAN_ADDR_OUT_EN
  ,parameter int ADDR_W = ADDR_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_dec,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ID_W-1:0]   in_id,
  input  logic [KEY_W-1:0]  key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ID_W-1:0]   out_id,
  output logic              weak_key
`ifdef RAVAN_ADDR_OUT_EN
  ,output logic [ADDR_W-1:0] out_addr
`endif
);

  localparam int NW = KEY_W / DATA_W;
  localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  localparam logic [1:0]    S_IDLE = IDLE;
  localparam logic [1:0]    S_RUN  = RUN;
  localparam logic [1:0]    S_DONE = DONE;
  localparam logic [CW-1:0] CNT_LAST = CW'(ROUNDS - 1);

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_x;
  logic              r_dec;
  logic [ID_W-1:0]   r_id;
  logic [KEY_W-1:0]  r_key;
  logic              r_weak;

  int                w_ri;
  logic [DATA_W-1:0] w_k;
  logic [DATA_W-1:0] w_x_next;

  // Handshake flags are pure decodes of the registered state.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_x;
  assign out_id    = r_id;
  assign weak_key  = r_weak;

  // Decrypt walks the round keys backwards off the same up-counter.
  always_comb begin
    w_ri = r_dec ? (ROUNDS - 1 - int'(r_cnt)) : int'(r_cnt);
    w_k  = DATA_W'(round_key(kbus_t'(r_key), w_ri, DATA_W, NW));
  end

  ravan_round #(
    .DATA_W (DATA_W),
    .ROT    (ROT)
  ) u_round (
    .x      (r_x),
    .k      (w_k),
    .dec    (r_dec),
    .x_next (w_x_next)
  );

  // FSM and datapath: latch at accept, iterate in RUN, hold in DONE until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_dec   <= 1'b0;
      r_id    <= '0;
      r_key   <= '0;
      r_weak  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x     <= in_data;
            r_dec   <= in_dec;
            r_id    <= in_id;
            r_key   <= key;
            r_cnt   <= '0;
            r_state <= S_RUN;
            if (key == '0) r_weak <= 1'b1;
          end
        end
        S_RUN: begin
          r_x   <= w_x_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef RAVAN_ADDR_OUT_EN
  localparam int NS = (KEY_W + ADDR_W - 1) / ADDR_W;

  logic [NS*ADDR_W-1:0] w_kpad;
  logic [ADDR_W-1:0]    w_fold;
  logic [ADDR_W-1:0]    r_addr;

  // Fold the incoming key into one address slice; a short top slice reads as zero.
  always_comb begin
    w_kpad              = '0;
    w_kpad[KEY_W-1:0]   = key;
    w_fold              = '0;
    for (int s = 0; s < NS; s++) w_fold = w_fold ^ w_kpad[s*ADDR_W +: ADDR_W];
  end

  // Address is captured alongside the key and held until the next accept.
  always_ff @(posedge clk) begin
    if (rst)                                r_addr <= '0;
    else if (r_state == S_IDLE && in_valid) r_addr <= w_fold;
  end

  assign out_addr = r_addr;
`endif

endmodule

// File: tb/tb_ravan_iter_cipher.sv
// Self-checking bench for ravan_iter_cipher (default 64/512/8 rounds/ROT 1).
// Reference model computes the cipher directly from the round definition.
module tb_ravan_iter_cipher;

  localparam int DW = 64;
  localparam int KW = 512;
  localparam int RN = 8;
  localparam int NW = KW / DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid, in_ready, in_dec;
  logic [DW-1:0] in_data;
  logic [3:0]    in_id;
  logic [KW-1:0] tb_key;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [3:0]    out_id;
  logic          weak_key;
`ifdef RAVAN_ADDR_OUT_EN
  logic [15:0]   out_addr;
`endif

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  ravan_iter_cipher #(
    .DATA_W (DW), .KEY_W (KW), .ROUNDS (RN), .ROT (1), .ID_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dec    (in_dec),
    .in_data   (in_data),
    .in_id     (in_id),
    .key       (tb_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .weak_key  (weak_key)
`ifdef RAVAN_ADDR_OUT_EN
    ,.out_addr (out_addr)
`endif
  );

  function automatic logic [DW-1:0] m_enc(input logic [DW-1:0] x, input logic [KW-1:0] k);
    logic [DW-1:0] v;
    v = x;
    for (int i = 0; i < RN; i++) begin
      v = v ^ k[(i % NW)*DW +: DW] ^ 64'(i);
      v = {v[DW-2:0], v[DW-1]};
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] m_dec(input logic [DW-1:0] x, input logic [KW-1:0] k);
    logic [DW-1:0] v;
    v = x;
    for (int i = RN - 1; i >= 0; i--) begin
      v = {v[0], v[DW-1:1]};
      v = v ^ k[(i % NW)*DW +: DW] ^ 64'(i);
    end
    return v;
  endfunction

  function automatic logic [KW-1:0] rand_key();
    logic [KW-1:0] k;
    for (int q = 0; q < KW/32; q++) k[q*32 +: 32] = $urandom();
    return k;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one block from a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic dec, input logic [DW-1:0] d, input logic [3:0] id,
                      input logic [KW-1:0] k);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    in_valid = 1'b1; in_dec = dec; in_data = d; in_id = id; tb_key = k;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for the result (bounded), note whether in_ready rose while busy, then take it.
  task automatic collect(output logic [DW-1:0] d, output logic [3:0] id,
                         output int lat, output logic rdy_seen);
    lat = 1; rdy_seen = 1'b0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (in_ready !== 1'b0) rdy_seen = 1'b1;
    d = out_data; id = out_id;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d, d2, x, c, sd;
    logic [3:0]    id, sid;
    logic [KW-1:0] k, k2;
    logic          rdy, stable, vseen;
    int            lat, w;

    in_valid = 1'b0; in_dec = 1'b0; in_data = '0; in_id = '0; tb_key = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  out_data,       64'd0);
    chk("rst_out_id",    64'(out_id),    64'd0);
    chk("rst_weak_key",  64'(weak_key),  64'd0);
    rst = 1'b0;
    @(negedge clk);

    // All-zero key: known-answer vector, latency, weak flag.
    send(1'b0, 64'd0, 4'd3, '0);
    collect(d, id, lat, rdy);
    chk("kat_enc_data", d, 64'h1E);
    chk("kat_enc_id",   64'(id), 64'd3);
    chk("kat_latency",  64'(lat), 64'(RN + 1));
    chk("kat_busy_rdy", 64'(rdy), 64'd0);
    chk("kat_weak_set", 64'(weak_key), 64'd1);

    send(1'b1, 64'h1E, 4'd5, '0);
    collect(d, id, lat, rdy);
    chk("kat_dec_data", d, 64'd0);
    chk("kat_dec_id",   64'(id), 64'd5);
    chk("kat_weak_hold", 64'(weak_key), 64'd1);

    // Random key, random blocks: encrypt against model, decrypt back to original.
    k = rand_key();
    for (int n = 0; n < 1000; n++) begin
      x = {$urandom(), $urandom()};
      send(1'b0, x, 4'(n), k);
      collect(c, id, lat, rdy);
      chk("rnd_enc", c, m_enc(x, k));
      chk("rnd_enc_busy", 64'({rdy, lat == RN + 1}), 64'b01);
      send(1'b1, c, 4'(n + 1), k);
      collect(d, id, lat, rdy);
      chk("rnd_dec", d, x);
      chk("rnd_dec_tag", 64'({rdy, id}), 64'({1'b0, 4'(n + 1)}));
    end

    // Back-pressure in DONE, then release and immediate re-accept.
    x = {$urandom(), $urandom()};
    send(1'b0, x, 4'd9, k);
    w = 0;
    while (out_valid !== 1'b1 && w < 40) begin @(negedge clk); w++; end
    sd = out_data; sid = out_id; stable = 1'b1;
    chk("stall_data", sd, m_enc(x, k));
    chk("stall_id",   64'(sid), 64'd9);
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== sd || out_id !== sid || in_ready !== 1'b0) stable = 1'b0;
    end
    chk("stall_stable", 64'(stable), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_in_ready",  64'(in_ready),  64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);
    d2 = {$urandom(), $urandom()};
    in_valid = 1'b1; in_dec = 1'b0; in_data = d2; in_id = 4'd4; tb_key = k;
    @(negedge clk);
    in_valid = 1'b0;
    chk("reaccept_busy", 64'(in_ready), 64'd0);
    collect(d, id, lat, rdy);
    chk("reaccept_data", d, m_enc(d2, k));

    // Inputs changing mid-RUN must not disturb the latched transaction.
    k2 = rand_key();
    x = {$urandom(), $urandom()};
    send(1'b0, x, 4'd7, k2);
    repeat (2) @(negedge clk);
    in_valid = 1'b1; in_dec = 1'b1; in_data = ~x; in_id = 4'd2; tb_key = ~k2;
    collect(d, id, lat, rdy);
    in_valid = 1'b0;
    chk("midrun_data", d, m_enc(x, k2));
    chk("midrun_id",   64'(id), 64'd7);

    // Reset in the middle of RUN aborts the block.
    send(1'b0, x, 4'd1, k2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 64'(in_ready),  64'd1);
    chk("abort_weak_clr", 64'(weak_key),  64'd0);
    vseen = 1'b0;
    repeat (15) begin
      if (out_valid !== 1'b0) vseen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_result", 64'(vseen), 64'd0);

`ifdef RAVAN_ADDR_OUT_EN
    k = '0; k[15:0] = 16'h0001;
    send(1'b0, 64'd0, 4'd0, k);
    collect(d, id, lat, rdy);
    chk("addr_fold", 64'(out_addr), 64'h0001);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/ravan_iter_cipher.md
# ravan_iter_cipher

Parametrised, iterative successor to the fixed 64-bit RAVAN encrypt/decrypt datapath. It accepts one block per transaction over a valid/ready handshake and runs a per-transaction encrypt or decrypt mode. Rounds are computed one per cycle under an FSM, and a transaction ID is carried through to the result. It sits between the host stream and the RAVAN memory path and replaces the separate, always-running encryption and decryption cores.

## Interface
Parameters:
- DATA_W, 64, block width in bits; must divide KEY_W.
- KEY_W, 512, key width in bits.
- ROUNDS, 8, round count, ≥1.
- ROT, 1, per-round rotate amount, 0 < ROT < DATA_W.
- ID_W, 4, transaction tag width.
- ADDR_W, 16, memory address width, used only with the address feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input block valid.
- in_ready  out  1  block can be accepted.
- in_dec  in  1  0 = encrypt, 1 = decrypt.
- in_data  in  DATA_W  plaintext or ciphertext block.
- in_id  in  ID_W  transaction tag.
- key  in  KEY_W  cipher key; sampled at accept.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  result block.
- out_id  out  ID_W  tag of the result.
- weak_key  out  1  sticky flag: an all-zero key was accepted.
- out_addr  out  ADDR_W  key-reduced memory address; present only with RAVAN_ADDR_OUT_EN.

## Operation
- Number of key words: NW = KEY_W/DATA_W.
- Key words: w[j] = key[j*DATA_W +: DATA_W].
- Round key: k[i] = w[i mod NW] XOR i, where i is zero-extended to DATA_W.
- Encrypt: for i = 0..ROUNDS-1, x = rotl(x XOR k[i], ROT).
- Decrypt: for i = ROUNDS-1 down to 0, x = rotr(x, ROT) XOR k[i]. Decrypt is the exact inverse of encrypt.
- FSM states:
  - IDLE: in_ready = 1. On in_valid, latch in_data, in_dec, in_id and key; clear the round counter; go to RUN.
  - RUN: apply one round per cycle. The counter runs 0..ROUNDS-1 and is mapped to i = cnt for encrypt and i = ROUNDS-1-cnt for decrypt. After the round with cnt = ROUNDS-1, go to DONE.
  - DONE: out_valid = 1. out_data, out_id and out_addr are held stable. On out_ready, go to IDLE.
- Inputs are ignored outside IDLE, including any key change during RUN or DONE.
- weak_key sets when a transaction is accepted with key == 0, and clears only on rst.

## Timing
- Reset values:
  - State IDLE, in_ready = 1.
  - out_valid = 0, out_data = 0, out_id = 0.
  - weak_key = 0, out_addr = 0.
- Latency:
  - Accept edge at cycle t.
  - Rounds execute at the edges ending cycles t+1 .. t+ROUNDS.
  - out_valid is high from cycle t+ROUNDS+1.
- Throughput:
  - DONE with out_ready = 1 returns to IDLE on the next edge.
  - The next accept is possible one cycle later.
  - Minimum period is ROUNDS+2 cycles per block.
- in_ready is registered (a decode of the registered state) and does not depend combinationally on in_valid.
- out_valid, once high, stays high with stable data until out_ready is sampled high.
- Reset during RUN or DONE aborts the transaction, outputs no result, and returns to IDLE on the next edge.
- Round-counter width is clog2(ROUNDS) bits, minimum 1. Rotates wrap modulo DATA_W.

## Configuration
- RAVAN_ADDR_OUT_EN defined:
  - out_addr exists.
  - At accept it registers the XOR-fold of the latched key into ADDR_W-bit slices; a partial top slice is zero-padded.
  - Held through DONE.
- Not defined: the out_addr port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package ravan_pkg holds:
  - The state enum (IDLE, RUN, DONE).
  - Default parameter constants.
  - Functions rotl/rotr and round_key(key, i).
- Sub-module ravan_round: a combinational single round with inputs x, k, dec and output x_next. It is instantiated once and reused every RUN cycle.

## Test plan
- ROUNDS=8, ROT=1, key=0, encrypt in_data=0, in_id=3 → out_data=0x1E, out_id=3, out_valid at accept+9; weak_key=1.
- Same configuration, decrypt in_data=0x1E → out_data=0, weak_key stays 1.
- Random 512-bit key and 1000 random blocks, each encrypted then decrypted → original block recovered; in_ready low throughout RUN and DONE.
- Hold out_ready=0 for 5 cycles in DONE → out_valid/out_data/out_id stable; in_ready=0. Release → IDLE next edge; next accept one cycle later.
- Change key and in_data mid-RUN → result matches the key and data latched at accept.
- Assert rst at RUN cycle 4 → out_valid never rises, in_ready=1 after reset, weak_key=0. With RAVAN_ADDR_OUT_EN and key = 0x0001 in slice 0 only → out_addr=0x0001.
